// File: rtl/sram_controller_wide.sv
// rtl/sram_controller_wide.sv - host-width to 16-bit async SRAM controller with per-beat wait states
module sram_controller_wide #(
  parameter int DATA_W      = 32,
  parameter int SRAM_ADDR_W = 20,
  parameter int WAIT_CYCLES = 2,
  localparam int BEATS       = DATA_W / 16,
  localparam int BEAT_W      = $clog2(BEATS),
  localparam int HOST_ADDR_W = SRAM_ADDR_W - BEAT_W
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [HOST_ADDR_W-1:0] controller_address,
  input  logic [DATA_W/8-1:0]    controller_byteenable,
  input  logic                   controller_read,
  input  logic                   controller_write,
  input  logic [DATA_W-1:0]      controller_writedata,
  output logic [DATA_W-1:0]      controller_readdata,
  output logic                   controller_readdatavalid,
  output logic                   controller_waitrequest,
  inout  wire  [15:0]            sram_DQ,
  output logic [SRAM_ADDR_W-1:0] sram_ADDR,
  output logic                   sram_LB_N,
  output logic                   sram_UB_N,
  output logic                   sram_CE_N,
  output logic                   sram_OE_N,
  output logic                   sram_WE_N
);

  // Beat index is kept at least one bit wide so the 16-bit build needs no special casing.
  localparam int IDX_W = (BEAT_W == 0) ? 1 : BEAT_W;
  localparam int CNT_W = (WAIT_CYCLES <= 1) ? 1 : $clog2(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, RD, WR, WREC} state_t;

  state_t               state;
  logic [IDX_W-1:0]     beat;
  logic [CNT_W-1:0]     wcnt;
  logic [HOST_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W/8-1:0]  be_q;
  logic                 dq_oe;
  logic [15:0]          dq_out;

  logic [IDX_W:0]       first_hit;
  logic [IDX_W:0]       later_hit;
  logic [1:0]           first_lanes;
  logic [1:0]           later_lanes;
  logic [15:0]          first_data;
  logic [15:0]          later_data;
  logic                 beat_done;
  logic                 last_beat;

  // Lowest beat at or above 'from' whose 2-bit enable is nonzero; MSB flags a hit.
  function automatic logic [IDX_W:0] next_beat(input logic [DATA_W/8-1:0] be, input int from);
    next_beat = '0;
    for (int i = BEATS - 1; i >= 0; i--)
      if (i >= from && be[2*i +: 2] != 2'b00)
        next_beat = {1'b1, IDX_W'(i)};
  endfunction

  // SRAM half-word address of a beat: host address with the beat index appended.
  function automatic logic [SRAM_ADDR_W-1:0] beat_addr(input logic [HOST_ADDR_W-1:0] a,
                                                        input logic [IDX_W-1:0] b);
    beat_addr = (SRAM_ADDR_W'(a) << BEAT_W) | SRAM_ADDR_W'(b);
  endfunction

  assign sram_DQ = dq_oe ? dq_out : 16'hzzzz;

  // Next-beat selection for a freshly accepted write and for the write in flight.
  always_comb begin
    first_hit   = next_beat(controller_byteenable, 0);
    later_hit   = next_beat(be_q, int'(beat) + 1);
    first_lanes = controller_byteenable[2*int'(first_hit[IDX_W-1:0]) +: 2];
    later_lanes = be_q[2*int'(later_hit[IDX_W-1:0]) +: 2];
    first_data  = controller_writedata[16*int'(first_hit[IDX_W-1:0]) +: 16];
    later_data  = wdata_q[16*int'(later_hit[IDX_W-1:0]) +: 16];
    beat_done   = (wcnt == CNT_W'(WAIT_CYCLES - 1));
    last_beat   = (beat == IDX_W'(BEATS - 1));
  end

  // Transaction FSM; every pin and host output is registered and set on state entry.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state                    <= IDLE;
      beat                     <= '0;
      wcnt                     <= '0;
      addr_q                   <= '0;
      wdata_q                  <= '0;
      be_q                     <= '0;
      dq_oe                    <= 1'b0;
      dq_out                   <= '0;
      controller_readdata      <= '0;
      controller_readdatavalid <= 1'b0;
      controller_waitrequest   <= 1'b0;
      sram_ADDR                <= '0;
      sram_LB_N                <= 1'b1;
      sram_UB_N                <= 1'b1;
      sram_CE_N                <= 1'b1;
      sram_OE_N                <= 1'b1;
      sram_WE_N                <= 1'b1;
    end else begin
      controller_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (controller_write) begin
            addr_q  <= controller_address;
            wdata_q <= controller_writedata;
            be_q    <= controller_byteenable;
            // An all-zero enable write is swallowed here without touching the pins.
            if (first_hit[IDX_W]) begin
              state                  <= WR;
              beat                   <= first_hit[IDX_W-1:0];
              wcnt                   <= '0;
              controller_waitrequest <= 1'b1;
              sram_ADDR              <= beat_addr(controller_address, first_hit[IDX_W-1:0]);
              sram_CE_N              <= 1'b0;
              sram_WE_N              <= 1'b0;
              sram_OE_N              <= 1'b1;
              sram_UB_N              <= ~first_lanes[1];
              sram_LB_N              <= ~first_lanes[0];
              dq_oe                  <= 1'b1;
              dq_out                 <= first_data;
            end
          end else if (controller_read) begin
            addr_q                 <= controller_address;
            state                  <= RD;
            beat                   <= '0;
            wcnt                   <= '0;
            controller_waitrequest <= 1'b1;
            sram_ADDR              <= beat_addr(controller_address, '0);
            sram_CE_N              <= 1'b0;
            sram_OE_N              <= 1'b0;
            sram_WE_N              <= 1'b1;
            sram_LB_N              <= 1'b0;
            sram_UB_N              <= 1'b0;
          end
        end
        RD: begin
          if (beat_done) begin
            controller_readdata[16*int'(beat) +: 16] <= sram_DQ;
            wcnt <= '0;
            if (last_beat) begin
              state                    <= IDLE;
              controller_waitrequest   <= 1'b0;
              controller_readdatavalid <= 1'b1;
              sram_CE_N                <= 1'b1;
              sram_OE_N                <= 1'b1;
              sram_LB_N                <= 1'b1;
              sram_UB_N                <= 1'b1;
            end else begin
              beat      <= beat + IDX_W'(1);
              sram_ADDR <= beat_addr(addr_q, beat + IDX_W'(1));
            end
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        WR: begin
          if (beat_done) begin
            state     <= WREC;
            wcnt      <= '0;
            sram_WE_N <= 1'b1;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        WREC: begin
          // Recovery keeps DQ driven; the bus is only released on the way back to IDLE.
          if (later_hit[IDX_W]) begin
            state     <= WR;
            beat      <= later_hit[IDX_W-1:0];
            sram_ADDR <= beat_addr(addr_q, later_hit[IDX_W-1:0]);
            sram_WE_N <= 1'b0;
            sram_UB_N <= ~later_lanes[1];
            sram_LB_N <= ~later_lanes[0];
            dq_out    <= later_data;
          end else begin
            state                  <= IDLE;
            controller_waitrequest <= 1'b0;
            sram_CE_N              <= 1'b1;
            sram_WE_N              <= 1'b1;
            sram_OE_N              <= 1'b1;
            sram_LB_N              <= 1'b1;
            sram_UB_N              <= 1'b1;
            dq_oe                  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller_wide.sv
// tb/tb_sram_controller_wide.sv - randomized bench with host-level memory model for sram_controller_wide
module tb_sram_controller_wide;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;

  // 32-bit, two wait cycles per beat
  logic [18:0] address = '0;
  logic [3:0]  byteenable = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        rdv, waitreq;
  wire  [15:0] dq;
  logic [19:0] sram_addr;
  logic        lb_n, ub_n, ce_n, oe_n, we_n;

  // 16-bit, one wait cycle per beat
  logic [7:0]  n_address = '0;
  logic [1:0]  n_byteenable = '0;
  logic        n_rd = 1'b0, n_wr = 1'b0;
  logic [15:0] n_writedata = '0;
  logic [15:0] n_readdata;
  logic        n_rdv, n_waitreq;
  wire  [15:0] n_dq;
  logic [7:0]  n_sram_addr;
  logic        n_lb_n, n_ub_n, n_ce_n, n_oe_n, n_we_n;

  sram_controller_wide #(.DATA_W(32), .SRAM_ADDR_W(20), .WAIT_CYCLES(W)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .controller_address(address), .controller_byteenable(byteenable),
    .controller_read(rd), .controller_write(wr), .controller_writedata(writedata),
    .controller_readdata(readdata), .controller_readdatavalid(rdv),
    .controller_waitrequest(waitreq), .sram_DQ(dq), .sram_ADDR(sram_addr),
    .sram_LB_N(lb_n), .sram_UB_N(ub_n), .sram_CE_N(ce_n), .sram_OE_N(oe_n), .sram_WE_N(we_n)
  );

  sram_controller_wide #(.DATA_W(16), .SRAM_ADDR_W(8), .WAIT_CYCLES(1)) dut16 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .controller_address(n_address), .controller_byteenable(n_byteenable),
    .controller_read(n_rd), .controller_write(n_wr), .controller_writedata(n_writedata),
    .controller_readdata(n_readdata), .controller_readdatavalid(n_rdv),
    .controller_waitrequest(n_waitreq), .sram_DQ(n_dq), .sram_ADDR(n_sram_addr),
    .sram_LB_N(n_lb_n), .sram_UB_N(n_ub_n), .sram_CE_N(n_ce_n), .sram_OE_N(n_oe_n), .sram_WE_N(n_we_n)
  );

  function automatic logic [15:0] init_pat(input int i);
    if (i == 20) return 16'h1111;
    if (i == 21) return 16'h2222;
    return 16'(i * 40503 + 15450);
  endfunction

  // Async SRAM chips: drive on CE/OE read, latch enabled bytes while WE is low.
  logic [15:0] mem [0:1023];
  logic [15:0] mem16 [0:255];
  bit          mem_init = 1'b0;
  bit          mem16_init = 1'b0;

  assign dq   = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;
  assign n_dq = (!n_ce_n && !n_oe_n && n_we_n) ? mem16[n_sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = init_pat(i);
      mem_init = 1'b1;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[9:0]][7:0]  = dq[7:0];
      if (!ub_n) mem[sram_addr[9:0]][15:8] = dq[15:8];
    end
  end

  always @(posedge clk) begin
    if (!mem16_init) begin
      for (int i = 0; i < 256; i++) mem16[i] = init_pat(i);
      mem16_init = 1'b1;
    end else if (!n_ce_n && !n_we_n) begin
      if (!n_lb_n) mem16[n_sram_addr][7:0]  = n_dq[7:0];
      if (!n_ub_n) mem16[n_sram_addr][15:8] = n_dq[15:8];
    end
  end

  // Host-level view: one 32-bit word per host address.
  logic [31:0] ref_mem [0:511];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One host transaction, observed for a fixed window and judged against the host-level model.
  task automatic do_op(input bit r, input bit w, input logic [8:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int busy, rdv_n, rdv_at, we_cnt, ce_cnt, pin_bad, n, b;
    logic [31:0] rdata;
    busy = 0; rdv_n = 0; rdv_at = 0; we_cnt = 0; ce_cnt = 0; pin_bad = 0; rdata = '0;
    @(negedge clk);
    check("idle_before_op", waitreq, 0);
    rd = r; wr = w; address = 19'(a); writedata = d; byteenable = be;
    @(posedge clk);
    #1 rd = 1'b0; wr = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      busy += int'(waitreq);
      if (rdv) begin rdv_n++; rdv_at = j; rdata = readdata; end
      if (!ce_n) ce_cnt++;
      if (!oe_n && !we_n) pin_bad++;
      if (!we_n) begin
        we_cnt++;
        b = int'(sram_addr) - 2 * int'(a);
        if (b < 0 || b > 1) pin_bad++;
        else if ({ub_n, lb_n} !== ~be[2*b +: 2] || dq !== d[16*b +: 16]) pin_bad++;
      end
      if (r && !w && j <= 2 * W)
        if (sram_addr !== 20'(2 * int'(a) + (j - 1) / W) || oe_n || ce_n || !we_n) pin_bad++;
    end
    n = int'(be[1:0] != 2'b00) + int'(be[3:2] != 2'b00);
    if (w) begin
      check("write_busy", busy, n * (W + 1));
      check("write_we_low", we_cnt, n * W);
      check("write_no_rdv", rdv_n, 0);
      if (n == 0) check("write_be0_ce", ce_cnt, 0);
      for (int k = 0; k < 4; k++) if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
    end else begin
      check("read_busy", busy, 2 * W);
      check("read_rdv_count", rdv_n, 1);
      check("read_rdv_cycle", rdv_at, 2 * W + 1);
      check("read_data", rdata, ref_mem[a]);
      check("read_data_hold", readdata, ref_mem[a]);
    end
    check("pins", pin_bad, 0);
  endtask

  task automatic wait_rdv(input string tag, input logic [8:0] a, output bit found);
    found = 1'b0;
    for (int j = 1; j <= 10 && !found; j++) begin
      @(negedge clk);
      if (rdv) begin
        found = 1'b1;
        check({tag, "_cycle"}, j, 2 * W + 1);
        check({tag, "_data"}, readdata, ref_mem[a]);
      end
    end
    if (!found) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    bit found;
    int busy, rdv_n, op;
    for (int a = 0; a < 512; a++) ref_mem[a] = {init_pat(2 * a + 1), init_pat(2 * a)};

    // reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_waitreq", waitreq, 0);
    check("rst_rdv", rdv, 0);
    check("rst_readdata", readdata, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_ctl", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'h1f);
    check("rst16_waitreq", n_waitreq, 0);

    // reset in the middle of a read
    rd = 1'b1; address = 19'd5;
    @(posedge clk);
    #1 rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrd_active", ce_n, 0);
    rst_n = 1'b0;
    #1;
    check("midrd_rst_ctl", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'h1f);
    check("midrd_rst_addr", sram_addr, 0);
    check("midrd_rst_waitreq", waitreq, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdv_n = 0;
    repeat (8) begin @(negedge clk); rdv_n += int'(rdv); end
    check("midrd_no_rdv", rdv_n, 0);
    check("midrd_readdata", readdata, 0);

    // full read, full write, partial writes, simultaneous read and write
    do_op(1'b1, 1'b0, 9'h00A, 32'h0, 4'h0);
    do_op(1'b0, 1'b1, 9'h003, 32'hDEADBEEF, 4'hF);
    check("full_write_lo", mem[6], 16'hBEEF);
    check("full_write_hi", mem[7], 16'hDEAD);
    do_op(1'b0, 1'b1, 9'h003, 32'h12345678, 4'b0100);
    check("partial_write", mem[7], 16'hDE34);
    check("partial_write_lo", mem[6], 16'hBEEF);
    do_op(1'b0, 1'b1, 9'h003, 32'hCAFEF00D, 4'b0000);
    do_op(1'b1, 1'b1, 9'h020, 32'hA5A55A5A, 4'hF);
    do_op(1'b1, 1'b0, 9'h020, 32'h0, 4'h0);

    // back-to-back reads, the second accepted in the first one's valid cycle
    @(negedge clk);
    rd = 1'b1; address = 19'h003;
    @(posedge clk);
    #1 rd = 1'b0;
    wait_rdv("b2b_first", 9'h003, found);
    if (found) begin rd = 1'b1; address = 19'h020; end
    @(posedge clk);
    #1 rd = 1'b0;
    wait_rdv("b2b_second", 9'h020, found);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 3));
      do_op(op != 2, op >= 2, 9'($urandom_range(0, 511)), $urandom, 4'($urandom));
    end

    // 16-bit build, single wait cycle
    @(negedge clk);
    n_rd = 1'b1; n_address = 8'h35;
    @(posedge clk);
    #1 n_rd = 1'b0;
    @(negedge clk);
    check("n16_addr", n_sram_addr, 8'h35);
    check("n16_rdv_early", n_rdv, 0);
    @(negedge clk);
    check("n16_rdv", n_rdv, 1);
    check("n16_rdata", n_readdata, init_pat(8'h35));
    n_wr = 1'b1; n_address = 8'h40; n_writedata = 16'h1234; n_byteenable = 2'b11;
    @(posedge clk);
    #1 n_wr = 1'b0;
    busy = 0;
    repeat (5) begin @(negedge clk); busy += int'(n_waitreq); end
    check("n16_write_busy", busy, 2);
    check("n16_write_mem", mem16[8'h40], 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller_wide.md
# sram_controller_wide

Parametrised controller for the board's 16-bit asynchronous SRAM that presents a host word of 16, 32 or 64 bits. It splits each host access into 16-bit SRAM beats and inserts a configurable number of wait cycles per beat. Back-pressure is signalled by `controller_waitrequest`, and read completion by a one-cycle `controller_readdatavalid` pulse. It sits between the core's memory port and the SRAM pins.

## Interface
- `DATA_W`, 32: host data width; legal values 16, 32, 64. Derived `BEATS = DATA_W/16`.
- `SRAM_ADDR_W`, 20: SRAM half-word address width. Derived `HOST_ADDR_W = SRAM_ADDR_W - log2(BEATS)`.
- `WAIT_CYCLES`, 2: cycles per SRAM beat; must be at least 1.

- `clk_clk` in 1: single clock.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `controller_address` in HOST_ADDR_W: host word address.
- `controller_byteenable` in DATA_W/8: write byte lanes; ignored for reads.
- `controller_read` in 1: read request.
- `controller_write` in 1: write request.
- `controller_writedata` in DATA_W: write data.
- `controller_readdata` out DATA_W: read data; registered.
- `controller_readdatavalid` out 1: one-cycle pulse when read data is valid.
- `controller_waitrequest` out 1: high means the request is not accepted.
- `sram_DQ` inout 16: SRAM data bus; driven only during writes.
- `sram_ADDR` out SRAM_ADDR_W: SRAM address.
- `sram_LB_N`, `sram_UB_N`, `sram_CE_N`, `sram_OE_N`, `sram_WE_N` out 1 each: active-low SRAM controls.

## Operation
- States: IDLE, RD, WR, WREC.
- `controller_waitrequest` is low in IDLE and high in every other state.
- **Acceptance:** a request is accepted at the rising edge where the FSM is in IDLE and `controller_read` or `controller_write` is high.
  - Address, write data and byte enables are latched at that edge.
  - If read and write are both high, the write wins and the read is dropped.
- **Beat mapping:** beat `i` addresses `sram_ADDR = {address, i}`, with `i` occupying log2(BEATS) bits (none for DATA_W=16).
  - Beat `i` carries data bits `[16i+15:16i]`.
  - Beat `i` uses byteenable `[2i+1:2i]`: `UB_N = ~be[2i+1]`, `LB_N = ~be[2i]`.
- **Read (RD):** all beats run, in order 0..BEATS-1.
  - Each beat lasts WAIT_CYCLES cycles with `CE_N=0`, `OE_N=0`, `LB_N=UB_N=0`, `WE_N=1`, and DQ at high-Z.
  - `sram_DQ` is sampled into lane `i` of `controller_readdata` at the edge ending the beat.
  - After the last beat the FSM returns to IDLE, and `controller_readdatavalid` is high for exactly the following cycle.
- **Write (WR, WREC):** only beats with a nonzero 2-bit enable run; disabled beats are skipped with no SRAM cycle.
  - WR lasts WAIT_CYCLES cycles with `CE_N=0`, `WE_N=0`, `OE_N=1`, and DQ driving the beat's half-word.
  - WREC is one recovery cycle with `WE_N=1`; address, data and DQ drive are held.
  - After WREC the FSM moves to the next enabled beat, or to IDLE if none remain.
  - A write with all byteenables zero is accepted and discarded: the FSM stays in IDLE and no SRAM pins toggle.
- **`controller_readdata`** holds its value until the next read completes. Lanes not yet rewritten during a read keep their old values until their beat ends.

## Timing
- **Reset:** asynchronous and immediate, including mid-transaction; the transaction in flight is dropped with no readdatavalid. Reset values:
  - FSM = IDLE.
  - `controller_waitrequest=0`, `controller_readdatavalid=0`, `controller_readdata=0`.
  - `sram_ADDR=0`; `CE_N`, `OE_N`, `WE_N`, `LB_N`, `UB_N` all = 1; DQ at high-Z.
- **Registered outputs:** all SRAM outputs are registered and update at the edge that enters the state. When IDLE is entered, `sram_ADDR` holds its last value and the controls return to 1.
- **Read latency:** for a read accepted at edge k, `controller_readdatavalid` is high in cycle k + BEATS·WAIT_CYCLES + 1.
- **Write busy time:** `controller_waitrequest` is high for `N·(WAIT_CYCLES+1)` cycles, where N is the number of enabled beats.
- **Back-to-back:** a new request can be accepted in the same cycle that `controller_readdatavalid` is high, with no dead cycle between transactions.
- **Bus turnaround:**
  - DQ is released at the edge leaving WREC.
  - `OE_N` is never low in the same cycle that DQ is driven.
  - Read-after-write is safe because WREC always precedes IDLE.

## Test plan
1. **Reset values:** assert reset for 3 cycles, then release → all outputs at their reset values and `controller_waitrequest=0`. Then assert reset mid-RD → pins return to reset values in the same cycle and no `controller_readdatavalid` follows.
2. **Full read (DATA_W=32, WAIT_CYCLES=2):** SRAM model holds 0x1111 at 0x00014 and 0x2222 at 0x00015; read at address 0x0000A accepted at edge k → `sram_ADDR` is 0x00014 for cycles k+1..k+2 and 0x00015 for k+3..k+4; `controller_readdatavalid` high only in cycle k+5 with `controller_readdata=0x22221111`.
3. **Full write:** write 0xDEADBEEF, byteenable 1111, to address 0x00003 → SRAM[0x00006]=0xBEEF and SRAM[0x00007]=0xDEAD; `WE_N` low for 2 cycles, then 1 recovery cycle, per beat; `controller_waitrequest` high for 6 cycles.
4. **Partial writes:**
   - byteenable 0100 → only beat 1 runs, with `LB_N=0`, `UB_N=1`; SRAM[0x00007] low byte updated; busy 3 cycles.
   - byteenable 0000 → no pin activity and `controller_waitrequest` stays low.
5. **Simultaneous read and write:** both asserted with byteenable 1111 → write performed and no `controller_readdatavalid` pulse. Then a back-to-back read accepted in the `controller_readdatavalid` cycle of a prior read → both complete with the correct data.
6. **DATA_W=16, WAIT_CYCLES=1:** read → `controller_readdatavalid` in cycle k+2; write → busy 2 cycles; `sram_ADDR` equals the host address.
